// File: rtl/seq_core_branch_ctrl.sv
// seq_core_branch_ctrl
// Stage-2 control unit of the pipelined seq_core. Holds the stage-2
// instruction register, resolves jumps, detects load-use hazards and runs
// the RUN/HALT state machine that freezes the fetch stage.
//
// Parameters:
//   A_SIZE  program counter / jump target width (>= 6)
//   D_SIZE  register data width (>= A_SIZE)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ir              instruction arriving from fetch
//   resume          one-cycle pulse that leaves HALT
//   rd_addr         register index read for the instruction in r2_ir
//   rd_data         forwarded value of register rd_addr
//   r2_ir           stage-2 instruction register
//   r2_pc_halt      freeze PC/IR
//   r2_pc_load      absolute jump to r2_pc_target
//   r2_pc_loadr     relative jump by signed r2_pc_target
//   r2_pc_target    jump address / offset (0 when no jump)
//   r2_pc_flush     replace the fetched IR with a NOP
//   bubble          hold PC/IR for one cycle (load-use hazard)
//
// Optional build macro SEQ_CORE_BRANCH_STATS_EN adds saturating counters
// taken_cnt, bubble_cnt and halt_cnt (cleared by rst).
module seq_core_branch_ctrl #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ir,
    input  logic              resume,
    output logic [2:0]        rd_addr,
    input  logic [D_SIZE-1:0] rd_data,
    output logic [15:0]       r2_ir,
    output logic              r2_pc_halt,
    output logic              r2_pc_load,
    output logic              r2_pc_loadr,
    output logic [A_SIZE-1:0] r2_pc_target,
    output logic              r2_pc_flush,
`ifdef SEQ_CORE_BRANCH_STATS_EN
    output logic [15:0]       taken_cnt,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       halt_cnt,
`endif
    output logic              bubble
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_JMPR  = 4'b1001;
    localparam logic [3:0] OP_JMPRC = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic              state;
    logic [3:0]        r2_op;
    logic [3:0]        ir_op;
    logic              halting;
    logic              cond_true;
    logic              jump_abs;
    logic              jump_rel;
    logic              jump;
    logic              ir_reads_dest;
    logic [2:0]        load_dest;
    logic [A_SIZE-1:0] rel_offset;

    assign r2_op     = r2_ir[15:12];
    assign ir_op     = ir[15:12];
    assign load_dest = r2_ir[10:8];

    // Casting the signed 6-bit field to A_SIZE sign-extends it.
    assign rel_offset = A_SIZE'($signed(r2_ir[5:0]));

    // Halt is asserted on the cycle the HALT opcode sits in r2, before the
    // state register has switched, so fetch freezes without a gap.
    assign halting = (state == ST_HALT) || (r2_op == OP_HALT);

    always_comb begin
        cond_true = 1'b0;
        case (r2_ir[11:9])
            3'b000:  cond_true = rd_data[D_SIZE-1];
            3'b001:  cond_true = !rd_data[D_SIZE-1];
            3'b010:  cond_true = (rd_data == '0);
            3'b011:  cond_true = (rd_data != '0);
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        rd_addr = 3'd0;
        if (r2_op == OP_JMP)
            rd_addr = r2_ir[2:0];
        else if (r2_op == OP_JMPRC)
            rd_addr = r2_ir[8:6];
    end

    assign jump_abs = !halting && (r2_op == OP_JMP);
    assign jump_rel = !halting && ((r2_op == OP_JMPR) ||
                                   ((r2_op == OP_JMPRC) && cond_true));
    assign jump     = jump_abs || jump_rel;

    // Does the incoming instruction read the register the LOAD in r2 writes?
    always_comb begin
        ir_reads_dest = 1'b0;
        case (ir_op)
            OP_JMP:   ir_reads_dest = (ir[2:0] == load_dest);
            OP_JMPRC: ir_reads_dest = (ir[8:6] == load_dest);
            OP_NOP, OP_LOAD, OP_JMPR, OP_HALT:
                      ir_reads_dest = 1'b0;
            default:  ir_reads_dest = (ir[5:3] == load_dest) ||
                                      (ir[2:0] == load_dest);
        endcase
    end

    always_comb begin
        r2_pc_halt   = halting;
        r2_pc_load   = jump_abs;
        r2_pc_loadr  = jump_rel;
        r2_pc_flush  = jump;
        r2_pc_target = '0;
        if (jump_abs)
            r2_pc_target = rd_data[A_SIZE-1:0];
        else if (jump_rel)
            r2_pc_target = rel_offset;
        // A jump in r2 flushes the fetched IR, which removes the hazard.
        bubble = !halting && !jump && (r2_op == OP_LOAD) && ir_reads_dest;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            r2_ir <= '0;
        end else if (state == ST_HALT) begin
            if (resume) begin
                state <= ST_RUN;
                r2_ir <= '0;
            end
        end else if (r2_op == OP_HALT) begin
            // Entering HALT: keep the HALT opcode in r2 while frozen.
            state <= ST_HALT;
        end else if (jump || bubble) begin
            r2_ir <= '0;
        end else begin
            r2_ir <= ir;
        end
    end

`ifdef SEQ_CORE_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt  <= '0;
            bubble_cnt <= '0;
            halt_cnt   <= '0;
        end else begin
            if (jump && (taken_cnt != 16'hFFFF))
                taken_cnt <= taken_cnt + 16'd1;
            if (bubble && (bubble_cnt != 16'hFFFF))
                bubble_cnt <= bubble_cnt + 16'd1;
            if ((state == ST_HALT) && (halt_cnt != 16'hFFFF))
                halt_cnt <= halt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_core_branch_ctrl.sv
module tb_seq_core_branch_ctrl;

    localparam int A = 10;
    localparam int D = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   ir;
    logic          resume;
    logic [2:0]    rd_addr;
    logic [D-1:0]  rd_data;
    logic [15:0]   r2_ir;
    logic          r2_pc_halt;
    logic          r2_pc_load;
    logic          r2_pc_loadr;
    logic [A-1:0]  r2_pc_target;
    logic          r2_pc_flush;
    logic          bubble;
`ifdef SEQ_CORE_BRANCH_STATS_EN
    logic [15:0]   taken_cnt;
    logic [15:0]   bubble_cnt;
    logic [15:0]   halt_cnt;
`endif

    seq_core_branch_ctrl #(.A_SIZE(A), .D_SIZE(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .resume       (resume),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .r2_ir        (r2_ir),
        .r2_pc_halt   (r2_pc_halt),
        .r2_pc_load   (r2_pc_load),
        .r2_pc_loadr  (r2_pc_loadr),
        .r2_pc_target (r2_pc_target),
        .r2_pc_flush  (r2_pc_flush),
`ifdef SEQ_CORE_BRANCH_STATS_EN
        .taken_cnt    (taken_cnt),
        .bubble_cnt   (bubble_cnt),
        .halt_cnt     (halt_cnt),
`endif
        .bubble       (bubble)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]  r2;
        logic [2:0]   ra;
        logic         h;
        logic         ld;
        logic         ldr;
        logic         fl;
        logic         bb;
        logic [A-1:0] tg;
    } outs_t;

    typedef struct {
        string        name;
        logic [15:0]  instr;
        logic [15:0]  nxt;
        logic [31:0]  rd;
        outs_t        exp;
        logic [15:0]  exp_next;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t dut_outs();
        return '{r2_ir, rd_addr, r2_pc_halt, r2_pc_load, r2_pc_loadr,
                 r2_pc_flush, bubble, r2_pc_target};
    endfunction

    // Reference model: register-read rules of the instruction set.
    function automatic bit reads_reg(input logic [15:0] x, input logic [2:0] d);
        int op = int'(x[15:12]);
        if (op == 8)  return x[2:0] == d;
        if (op == 10) return x[8:6] == d;
        if (op == 0 || op == 2 || op == 9 || op == 15) return 0;
        return (x[5:3] == d) || (x[2:0] == d);
    endfunction

    function automatic outs_t predict(input bit halted, input logic [15:0] r2,
                                      input logic [15:0] nx, input logic [31:0] rd);
        outs_t o;
        int op, off, s, cond;
        bit taken;
        o = '0;
        o.r2 = r2;
        op = int'(r2[15:12]);
        if (op == 8)  o.ra = r2[2:0];
        if (op == 10) o.ra = r2[8:6];
        o.h = halted || (op == 15);
        off = int'(r2[5:0]);
        if (off >= 32) off = off - 64;
        s = $signed(rd);
        cond = int'(r2[11:9]);
        if (!o.h) begin
            taken = 0;
            if (op == 8) begin
                o.ld = 1;
                o.tg = A'(rd % (1 << A));
            end else if (op == 9) begin
                taken = 1;
            end else if (op == 10) begin
                taken = (cond == 0 && s < 0) || (cond == 1 && s >= 0) ||
                        (cond == 2 && s == 0) || (cond == 3 && s != 0);
            end
            if (taken) begin
                o.ldr = 1;
                o.tg  = A'((off + (1 << A)) % (1 << A));
            end
            o.fl = o.ld || o.ldr;
            o.bb = !o.fl && (op == 2) && reads_reg(nx, r2[10:8]);
        end
        return o;
    endfunction

    function automatic logic [15:0] gen_ir();
        int c = int'($urandom_range(0, 99));
        logic [15:0] lo = 16'($urandom);
        int alu_ops[10] = '{1, 3, 4, 5, 6, 7, 11, 12, 13, 14};
        if (c < 10) return 16'h0000;
        if (c < 30) return {4'(alu_ops[$urandom_range(0, 9)]), lo[11:0]};
        if (c < 45) return {4'b0010, lo[11:0]};
        if (c < 53) return {4'b1000, lo[11:0]};
        if (c < 61) return {4'b1001, lo[11:0]};
        if (c < 83) return {4'b1010, lo[11:0]};
        if (c < 86) return 16'hF000;
        return {4'b0011, lo[11:0]};
    endfunction

    function automatic logic [31:0] gen_rd();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'd7;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        outs_t e, a;
        bit m_halted;
        logic [15:0] m_r2;
        logic [15:0] hold_ir;

        rst = 1'b1; ir = '0; resume = 1'b0; rd_data = '0;

        //                name        instr     nxt       rd             r2 ra h ld ldr fl bb tg         next
        vecs.push_back('{"jmpr+5",   16'h9005, 16'h1234, 32'd0,        '{16'h9005,3'd0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h005}, 16'h0000});
        vecs.push_back('{"jmpr-2",   16'h903E, 16'h1234, 32'd0,        '{16'h903E,3'd0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h3FE}, 16'h0000});
        vecs.push_back('{"jc_eq_t",  16'hA543, 16'h1234, 32'd0,        '{16'hA543,3'd5,1'b0,1'b0,1'b1,1'b1,1'b0,10'h003}, 16'h0000});
        vecs.push_back('{"jc_eq_nt", 16'hA543, 16'h1234, 32'd7,        '{16'hA543,3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000}, 16'h1234});
        vecs.push_back('{"jmp_abs",  16'h8006, 16'h1234, 32'h0001_F2AB,'{16'h8006,3'd6,1'b0,1'b1,1'b0,1'b1,1'b0,10'h2AB}, 16'h0000});
        vecs.push_back('{"jc_lt_t",  16'hA07F, 16'h1234, 32'hFFFF_FFFF,'{16'hA07F,3'd1,1'b0,1'b0,1'b1,1'b1,1'b0,10'h3FF}, 16'h0000});
        vecs.push_back('{"jc_ge_nt", 16'hA241, 16'h4567, 32'hFFFF_FFFF,'{16'hA241,3'd1,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000}, 16'h4567});
        vecs.push_back('{"jc_rsvd",  16'hA801, 16'h4567, 32'd0,        '{16'hA801,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000}, 16'h4567});
        vecs.push_back('{"lu_alu_hz",16'h2300, 16'h3019, 32'd0,        '{16'h2300,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h000}, 16'h0000});
        vecs.push_back('{"lu_alu_ok",16'h2300, 16'h3021, 32'd0,        '{16'h2300,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000}, 16'h3021});
        vecs.push_back('{"lu_jmp_hz",16'h2300, 16'h8003, 32'd0,        '{16'h2300,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h000}, 16'h0000});
        vecs.push_back('{"lu_jc_hz", 16'h2300, 16'hA4C1, 32'd0,        '{16'h2300,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h000}, 16'h0000});
        vecs.push_back('{"halt_in",  16'hF000, 16'h9005, 32'd0,        '{16'hF000,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000}, 16'hF000});

        // Reset state
        tick();
        chk("reset_outs", 64'(dut_outs()), 64'(outs_t'('0)));

        foreach (vecs[i]) begin
            rst = 1'b1; ir = '0; rd_data = '0; resume = 1'b0;
            tick();
            rst = 1'b0; ir = vecs[i].instr;
            tick();
            ir = vecs[i].nxt; rd_data = vecs[i].rd;
            #1;
            chk({vecs[i].name, "_outs"}, 64'(dut_outs()), 64'(vecs[i].exp));
            tick();
            chk({vecs[i].name, "_next"}, 64'(r2_ir), 64'(vecs[i].exp_next));
        end

        // Load-use bubble lasts exactly one cycle, then the ALU op enters r2
        rst = 1'b1; tick(); rst = 1'b0;
        ir = 16'h2300; tick();
        ir = 16'h3019; #1;
        chk("bub_c0", 64'(bubble), 64'd1);
        tick();
        chk("bub_c1_r2", 64'(r2_ir), 64'h0);
        chk("bub_c1_bub", 64'(bubble), 64'd0);
        tick();
        chk("bub_c2_r2", 64'(r2_ir), 64'h3019);

        // HALT held for 20 cycles, then resume
        ir = 16'hF000; tick();
        ir = 16'h9005; rd_data = 32'd5;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("halt_hold", 64'({r2_pc_halt, r2_ir, r2_pc_loadr, r2_pc_flush}),
                64'({1'b1, 16'hF000, 1'b0, 1'b0}));
            tick();
        end
        resume = 1'b1; #1;
        chk("halt_resume_cyc", 64'(r2_pc_halt), 64'd1);
        tick();
        resume = 1'b0;
        chk("halt_exit", 64'({r2_pc_halt, r2_ir}), 64'({1'b0, 16'h0000}));
        tick();
        chk("after_exit_fetch", 64'(r2_ir), 64'h9005);

        // Reset while halted with a jump waiting in ir
        rst = 1'b1; tick(); rst = 1'b0;
        ir = 16'hF000; tick();
        ir = 16'h9005; tick(); tick();
        rst = 1'b1; rd_data = 32'h3FF; tick();
        chk("rst_in_halt", 64'(dut_outs()), 64'(outs_t'('0)));
`ifdef SEQ_CORE_BRANCH_STATS_EN
        chk("rst_counters", 64'({taken_cnt, bubble_cnt, halt_cnt}), 64'h0);
`endif
        rst = 1'b0; ir = 16'h0000; tick();
        chk("rst_state_run", 64'(r2_pc_halt), 64'd0);

        // Randomized run against the reference model
        rst = 1'b1; tick();
        m_halted = 0; m_r2 = '0;
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            resume  = ($urandom_range(0, 7) == 0);
            hold_ir = gen_ir();
            ir      = hold_ir;
            rd_data = gen_rd();
            #1;
            e = predict(m_halted, m_r2, ir, rd_data);
            a = dut_outs();
            chk("random", 64'(a), 64'(e));
            if (rst) begin
                m_halted = 0; m_r2 = '0;
            end else if (m_halted) begin
                if (resume) begin m_halted = 0; m_r2 = '0; end
            end else if (m_r2[15:12] == 4'hF) begin
                m_halted = 1;
            end else if (e.fl || e.bb) begin
                m_r2 = '0;
            end else begin
                m_r2 = hold_ir;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_core_branch_ctrl.md
Name: seq_core_branch_ctrl

Overview:
Stage-2 control unit of the pipelined seq_core. It receives the instruction register from the fetch stage and drives the fetch stage's control inputs: r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_target, r2_pc_flush and bubble. Its responsibilities are:
- resolve jumps
- detect load-use hazards
- run the halt/resume state machine

Parameters:
A_SIZE, 10, program counter / jump target width (minimum 6)
D_SIZE, 32, register data width (minimum A_SIZE)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ir  input  16  instruction from fetch stage
resume  input  1  leave HALT state (one-cycle pulse)
rd_addr  output  3  register index to read (combinational from r2_ir)
rd_data  input  D_SIZE  register value, already forwarded by integration
r2_ir  output  16  stage-2 instruction register, passed to later stages
r2_pc_halt  output  1  freeze PC/IR
r2_pc_load  output  1  absolute jump
r2_pc_loadr  output  1  relative jump
r2_pc_target  output  A_SIZE  jump address or signed offset
r2_pc_flush  output  1  replace fetched IR with 0 (NOP)
bubble  output  1  hold PC/IR for one cycle

Behaviour:
Decode of r2_ir (decided encoding):
- [15:12]=1000: JMP, target = rd_data[A_SIZE-1:0], rd_addr=[2:0].
- [15:12]=1001: JMPR, offset = sign-extended [5:0].
- [15:12]=1010: JMPRcond, cond=[11:9], rd_addr=[8:6], offset=[5:0].
  - Cond 000: rd_data<0 (signed). 001: >=0. 010: ==0. 011: !=0.
  - Cond 100-111 reserved: never taken.
- [15:12]=0010: LOAD, dest=[10:8].
- [15:12]=1111: HALT.
- All other nonzero opcodes are ALU ops reading [5:3] and [2:0].
- 16'h0000 is NOP.

Outputs:
- All outputs other than the r2_ir register are combinational from r2_ir, rd_data and state.
- Jump in r2_ir: r2_pc_load or r2_pc_loadr asserted that same cycle, and r2_pc_flush=1 to kill the wrong-path ir. Taken penalty is exactly 1 cycle.
- Not-taken conditional: no load, no flush.
- r2_pc_target = 0 when no jump is active.

r2_ir update each cycle, in priority order:
1. rst → 0
2. HALT state → hold
3. flush → 0
4. bubble → 0 (insert NOP)
5. otherwise → ir

Load-use bubble:
- bubble=1 when r2_ir is LOAD and ir is an ALU op whose [5:3] or [2:0] equals the LOAD dest, or ir is JMP/JMPRcond whose operand field equals the dest.
- A bubble lasts exactly one cycle, because the NOP then occupies r2.

Simultaneous events:
- A jump in r2 suppresses bubble (the flush wins).
- Entering HALT suppresses jump/bubble.

State machine RUN/HALT:
- RUN→HALT when r2_ir is HALT. r2_pc_halt=1 from that same cycle, and on every cycle while in HALT.
- HALT→RUN on resume. r2_ir clears to 0 on the exit edge; fetch continues from the held PC.
- resume in RUN is ignored.

Reset (including mid-HALT or mid-jump):
- State=RUN, r2_ir=0.
- All control outputs 0, r2_pc_target=0, rd_addr=0.

Optional Feature:
SEQ_CORE_BRANCH_STATS_EN:
- Defined: adds outputs taken_cnt[15:0] (taken jumps), bubble_cnt[15:0] (bubble cycles) and halt_cnt[15:0] (cycles in HALT).
  - The counters saturate at 16'hFFFF.
  - They clear on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. r2_ir=16'h9005 (JMPR +5): loadr=1, target=10'h005, flush=1 in the same cycle; next r2_ir=0.
2. JMPR offset 6'b111110: target=10'h3FE (−2), loadr=1.
3. JMPRcond cond=010, rd_data=0: loadr=1, flush=1. With rd_data=7: no loadr/flush, and the next ir is captured normally.
4. LOAD dest=3 in r2, ir = ALU op reading r3: bubble=1 for exactly one cycle, r2_ir=0 next, then the ALU op enters r2. ALU op reading r4 instead: no bubble.
5. HALT enters r2: r2_pc_halt=1 held for 20 cycles with r2_ir unchanged. resume pulse: halt drops the next cycle, and r2_ir=0.
6. rst asserted while in HALT with a pending jump ir: all outputs 0 the next cycle, state RUN. With SEQ_CORE_BRANCH_STATS_EN, the counters also read 0.
